// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder endpoint.
package mem_responder_pkg;

  localparam int unsigned MEM_WORD_BYTES = 4;
  localparam int unsigned MEM_ADDR_W     = 32;
  localparam int unsigned MEM_DATA_W     = 8 * MEM_WORD_BYTES;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                      write;
    logic [MEM_ADDR_W-1:0]     addr;
    logic [MEM_DATA_W-1:0]     wdata;
    logic [MEM_WORD_BYTES-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with byte-strobed writes and an enabled, registered read port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                                                 clk,
  input  logic                                                 en,
  input  logic                                                 we,
  input  logic [((DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1)-1:0] addr,
  input  logic [MEM_DATA_W-1:0]                                wdata,
  input  logic [MEM_WORD_BYTES-1:0]                            wstrb,
  output logic [MEM_DATA_W-1:0]                                rdata
);

  logic [MEM_DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [MEM_DATA_W-1:0] rdata_q;

  // Read data is only refreshed on an enabled read, so it holds while a response waits.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < MEM_WORD_BYTES; b++) begin
          if (wstrb[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint: one outstanding request, fixed wait states, valid/ready response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [MEM_ADDR_W-1:0]     req_addr,
  input  logic [MEM_DATA_W-1:0]     req_wdata,
  input  logic [MEM_WORD_BYTES-1:0] req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [MEM_DATA_W-1:0]     rsp_rdata,
  output logic                      rsp_err
);

  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_IDLE = MEM_IDLE;
  localparam logic [1:0] ST_WAIT = MEM_WAIT;
  localparam logic [1:0] ST_RESP = MEM_RESP;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  mem_req_t              req_q, req_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rd_gate_q, rd_gate_d;

  mem_req_t              req_in, cur;
  logic                  cur_err, ram_en, ram_we;
  logic [MEM_DATA_W-1:0] ram_rdata;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // In IDLE the live request drives the RAM so a latency-1 access completes on the accept edge.
  assign cur     = (state_q == ST_IDLE) ? req_in : req_q;
  assign cur_err = (cur.addr[1:0] != 2'b00) || ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          err_d = cur_err;
          cnt_d = req_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
          if (req_write ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1)) begin
            state_d = ST_RESP;
            ram_en  = !cur_err;
            ram_we  = req_write;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          ram_en  = !err_q;
          ram_we  = req_q.write;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = (state_d == ST_RESP) && err_d;
    rd_gate_d   = (state_d == ST_RESP) && !err_d && !req_d.write;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_gate_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_gate_q   <= rd_gate_d;
    end
  end

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cur.addr[AW+1:2]),
    .wdata (cur.wdata),
    .wstrb (cur.wstrb),
    .rdata (ram_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // RAM read register is not reset, so data is masked outside a successful read response.
  assign rsp_rdata = rd_gate_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: default instance plus a WRITE_LATENCY=3 instance.
module tb_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rst_b_n, sel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (req_valid & ~sel),
    .req_ready (a_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready & ~sel),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  mem_responder #(.WRITE_LATENCY(3)) dut3 (
    .clk       (clk),
    .reset     (rst_n & rst_b_n),
    .req_valid (req_valid & sel),
    .req_ready (b_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready & sel),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  assign req_ready_m = sel ? b_req_ready : a_req_ready;
  assign rsp_valid_m = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_rdata_m = sel ? b_rsp_rdata : a_rsp_rdata;
  assign rsp_err_m   = sel ? b_rsp_err   : a_rsp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-lane merge into a per-instance word store.
  task automatic predict(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output exp_t e);
    int key;
    logic [31:0] w;
    e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
    e.rdata = '0;
    key     = (int'(sel) << 20) | int'(a[21:2]);
    if (!e.err) begin
      w = mdl.exists(key) ? mdl[key] : 32'h0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
        mdl[key] = w;
      end else begin
        e.rdata = w;
      end
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata_m, e.rdata);
      check({tag, "_err"}, 32'(rsp_err_m), 32'(e.err));
    end
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int exp_lat, input int hold);
    exp_t e;
    int n;
    logic [31:0] rd0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    n = 0;
    while (!req_ready_m && n < 20) begin step(); n++; end
    check({tag, "_ready_idle"}, 32'(req_ready_m), 32'd1);
    predict(wr, addr, wd, ws, e);
    sb_q.push_back(e);
    step();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
    n = 1;
    while (!rsp_valid_m && n < 20) begin step(); n++; end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_ready_busy"}, 32'(req_ready_m), 32'd0);
    rd0 = rsp_rdata_m;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_valid_m), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata_m, rd0);
      check({tag, "_hold_ready"}, 32'(req_ready_m), 32'd0);
    end
    pop_compare(tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_valid_after"}, 32'(rsp_valid_m), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready_m), 32'd1);
  endtask

  initial begin
    logic [31:0] b2b_addr [3];
    int acc_cyc [3];
    int nacc, nrsp, cyc;

    rst_n = 1'b0; rst_b_n = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    step(); step();
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    check("rst3_req_ready", 32'(b_req_ready), 32'd1);
    rst_n = 1'b1;
    step();

    do_txn("wr_w0", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 1, 0);
    do_txn("wr_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0);
    do_txn("rd_10", 1'b0, 32'h10, 32'h0, 4'h0, 2, 0);
    do_txn("wr_20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1, 0);
    do_txn("wr_20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1, 0);
    do_txn("rd_20", 1'b0, 32'h20, 32'h0, 4'h0, 2, 0);
    do_txn("rd_mis", 1'b0, 32'h22, 32'h0, 4'h0, 2, 0);
    do_txn("wr_oor", 1'b1, 32'd4096, 32'hFFFF_FFFF, 4'hF, 1, 0);
    do_txn("rd_w0", 1'b0, 32'h0, 32'h0, 4'h0, 2, 0);
    do_txn("wr_nostrb", 1'b1, 32'h10, 32'h5555_5555, 4'h0, 1, 0);
    do_txn("rd_bp", 1'b0, 32'h10, 32'h0, 4'h0, 2, 5);

    // Back-to-back reads with request and response always offered.
    b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h0;
    nacc = 0; nrsp = 0; cyc = 0;
    req_write = 1'b0; req_addr = b2b_addr[0]; req_valid = 1'b1; rsp_ready = 1'b1;
    while ((nacc < 3 || nrsp < 3) && cyc < 60) begin
      if (req_valid && req_ready_m) begin
        exp_t e;
        acc_cyc[nacc] = cyc;
        predict(1'b0, req_addr, 32'h0, 4'h0, e);
        sb_q.push_back(e);
        nacc++;
      end
      if (rsp_valid_m) begin
        pop_compare("b2b");
        nrsp++;
      end
      step();
      cyc++;
      if (nacc == 3) req_valid = 1'b0;
      else req_addr = b2b_addr[nacc];
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("b2b_responses", 32'(nrsp), 32'd3);
    check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    check("final_rd_20", a_rsp_rdata, 32'h0);
    step();

    // Second instance: slow write completes, then a write is abandoned by reset mid-wait.
    sel = 1'b1;
    do_txn("b_wr_30", 1'b1, 32'h30, 32'h1234_5678, 4'hF, 3, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
    check("b_abort_ready", 32'(b_req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    step();
    check("b_abort_busy", 32'(b_req_ready), 32'd0);
    rst_b_n = 1'b0;
    #1;
    check("b_rst_req_ready", 32'(b_req_ready), 32'd1);
    check("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    check("b_rst_rsp_rdata", b_rsp_rdata, 32'd0);
    check("b_rst_rsp_err", 32'(b_rsp_err), 32'd0);
    step();
    rst_b_n = 1'b1;
    step(); step();
    do_txn("b_rd_30", 1'b0, 32'h30, 32'h0, 4'h0, 2, 0);
    check("b_rd_30_const", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
